// File: rtl/phy_rx_align.sv
// PHY receive aligner: per-lane bit-slip search for the COM character, byte
// framing once locked, and idle/data separation with gap-based loss of sync.
//
// state  | meaning
// HUNT   | sliding COM search on every bit
// CHECK  | byte framed; counting consecutive COM bytes toward SYNC_COUNT
// ACTIVE | aligned; non-COM bytes delivered, COM bytes treated as idle
module phy_rx_align #(
    parameter int          LANES      = 2,
    parameter logic [7:0]  COM        = 8'hBC,
    parameter int          SYNC_COUNT = 4,
    parameter int          MAX_GAP    = 16
) (
    input  logic                 clk_32f,
    input  logic                 reset_L,
    input  logic [LANES-1:0]     data_in,
    output logic [8*LANES-1:0]   data_out,
    output logic [LANES-1:0]     valid_out,
    output logic [LANES-1:0]     active_lane,
    output logic                 all_active
);

    localparam int CW = $clog2(SYNC_COUNT + 1);
    localparam int GW = $clog2(MAX_GAP + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        state_t          state;
        state_t          state_nx;
        logic [6:0]      sr;
        logic [7:0]      win;
        logic [2:0]      bit_cnt;
        logic [2:0]      bit_cnt_nx;
        logic [CW-1:0]   com_cnt;
        logic [CW-1:0]   com_cnt_nx;
        logic [GW-1:0]   gap_cnt;
        logic [GW-1:0]   gap_cnt_nx;
        logic            load_byte;
        logic [7:0]      lane_data;
        logic            lane_valid;
        logic            lane_active;

        // The oldest history bit never reaches the window, so only seven are kept.
        assign win = {sr, data_in[i]};

        always_comb begin
            state_nx   = state;
            bit_cnt_nx = bit_cnt + 3'd1;
            com_cnt_nx = com_cnt;
            gap_cnt_nx = gap_cnt;
            load_byte  = 1'b0;
            case (state)
                HUNT: begin
                    bit_cnt_nx = 3'd0;
                    if (win == COM) begin
                        com_cnt_nx = CW'(1);
                        gap_cnt_nx = '0;
                        state_nx   = (SYNC_COUNT == 1) ? ACTIVE : CHECK;
                    end
                end
                CHECK: begin
                    if (bit_cnt == 3'd7) begin
                        if (win == COM) begin
                            com_cnt_nx = com_cnt + CW'(1);
                            if (int'(com_cnt) + 1 == SYNC_COUNT) begin
                                gap_cnt_nx = '0;
                                state_nx   = ACTIVE;
                            end
                        end else begin
                            com_cnt_nx = '0;
                            bit_cnt_nx = 3'd0;
                            state_nx   = HUNT;
                        end
                    end
                end
                ACTIVE: begin
                    if (bit_cnt == 3'd7) begin
                        if (win == COM) begin
                            gap_cnt_nx = '0;
                        end else if (int'(gap_cnt) < MAX_GAP) begin
                            load_byte  = 1'b1;
                            gap_cnt_nx = gap_cnt + GW'(1);
                        end else begin
                            bit_cnt_nx = 3'd0;
                            com_cnt_nx = '0;
                            gap_cnt_nx = '0;
                            state_nx   = HUNT;
                        end
                    end
                end
                default: begin
                    bit_cnt_nx = 3'd0;
                    com_cnt_nx = '0;
                    gap_cnt_nx = '0;
                    state_nx   = HUNT;
                end
            endcase
        end

        always_ff @(posedge clk_32f or negedge reset_L) begin
            if (!reset_L) begin
                state       <= HUNT;
                sr          <= '0;
                bit_cnt     <= '0;
                com_cnt     <= '0;
                gap_cnt     <= '0;
                lane_data   <= '0;
                lane_valid  <= 1'b0;
                lane_active <= 1'b0;
            end else begin
                state       <= state_nx;
                sr          <= win[6:0];
                bit_cnt     <= bit_cnt_nx;
                com_cnt     <= com_cnt_nx;
                gap_cnt     <= gap_cnt_nx;
                lane_valid  <= load_byte;
                lane_active <= (state_nx == ACTIVE);
                if (load_byte) begin
                    lane_data <= win;
                end
            end
        end

        assign data_out[8*i +: 8] = lane_data;
        assign valid_out[i]       = lane_valid;
        assign active_lane[i]     = lane_active;
    end

    assign all_active = &active_lane;

endmodule

// File: tb/tb_phy_rx_align.sv
// Bench for phy_rx_align: directed lane scenarios plus randomized byte/slip
// traffic, all checked against a stream-level reference model of each lane.
module tb_phy_rx_align;

    localparam int         LANES = 2;
    localparam logic [7:0] COM   = 8'hBC;
    localparam int         SYNC  = 4;
    localparam int         MAXG  = 16;

    logic                 clk_32f;
    logic                 reset_L;
    logic [LANES-1:0]     data_in;
    logic [8*LANES-1:0]   data_out;
    logic [LANES-1:0]     valid_out;
    logic [LANES-1:0]     active_lane;
    logic                 all_active;

    phy_rx_align #(
        .LANES      (LANES),
        .COM        (COM),
        .SYNC_COUNT (SYNC),
        .MAX_GAP    (MAXG)
    ) dut (
        .clk_32f     (clk_32f),
        .reset_L     (reset_L),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active_lane (active_lane),
        .all_active  (all_active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each lane is a bit stream; once a COM is seen the lane is
    // locked to that bit position and every 8th bit after it closes a byte.
    int         cyc;
    int         m_win    [LANES];
    bit         m_locked [LANES];
    bit         m_synced [LANES];
    int         m_align  [LANES];
    int         m_run    [LANES];
    int         m_gap    [LANES];
    logic [7:0] m_data   [LANES];
    bit         m_valid  [LANES];
    int         pulses   [LANES];

    bit q0[$];
    bit q1[$];
    bit fill0;
    bit fill1;

    function automatic void model_reset();
        cyc = 0;
        for (int l = 0; l < LANES; l++) begin
            m_win[l]    = 0;
            m_locked[l] = 0;
            m_synced[l] = 0;
            m_align[l]  = 0;
            m_run[l]    = 0;
            m_gap[l]    = 0;
            m_data[l]   = 8'h00;
            m_valid[l]  = 0;
        end
    endfunction

    function automatic void model_edge(input logic rst_val, input logic [LANES-1:0] bits);
        if (!rst_val) begin
            model_reset();
            return;
        end
        cyc++;
        for (int l = 0; l < LANES; l++) begin
            int w;
            w = ((m_win[l] << 1) | int'(bits[l])) & 255;
            m_win[l]   = w;
            m_valid[l] = 0;
            if (!m_locked[l]) begin
                if (w == int'(COM)) begin
                    m_locked[l] = 1;
                    m_align[l]  = cyc;
                    m_run[l]    = 1;
                    m_gap[l]    = 0;
                    m_synced[l] = (SYNC == 1);
                end
            end else if ((cyc - m_align[l]) % 8 == 0) begin
                if (!m_synced[l]) begin
                    if (w == int'(COM)) begin
                        m_run[l]++;
                        if (m_run[l] == SYNC) begin
                            m_synced[l] = 1;
                            m_gap[l]    = 0;
                        end
                    end else begin
                        m_locked[l] = 0;
                        m_run[l]    = 0;
                    end
                end else if (w == int'(COM)) begin
                    m_gap[l] = 0;
                end else if (m_gap[l] < MAXG) begin
                    m_data[l]  = 8'(w);
                    m_valid[l] = 1;
                    m_gap[l]++;
                end else begin
                    m_locked[l] = 0;
                    m_synced[l] = 0;
                    m_run[l]    = 0;
                    m_gap[l]    = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    task automatic check_outputs();
        logic [LANES-1:0] exp_a;
        exp_a = {m_synced[1], m_synced[0]};
        chk("data_out", data_out, {m_data[1], m_data[0]});
        chk("valid_out", 16'(valid_out), 16'({m_valid[1], m_valid[0]}));
        chk("active_lane", 16'(active_lane), 16'(exp_a));
        chk("all_active", 16'(all_active), 16'(&exp_a));
        for (int l = 0; l < LANES; l++) begin
            if (valid_out[l] === 1'b1) pulses[l]++;
        end
    endtask

    task automatic step(input logic rst_val, input logic [LANES-1:0] bits);
        @(negedge clk_32f);
        reset_L = rst_val;
        data_in = bits;
        model_edge(rst_val, bits);
        @(posedge clk_32f);
        #1;
        check_outputs();
    endtask

    task automatic push_bit(input int lane, input bit b);
        if (lane == 0) q0.push_back(b);
        else           q1.push_back(b);
    endtask

    task automatic push_byte(input int lane, input logic [7:0] b);
        for (int k = 7; k >= 0; k--) push_bit(lane, b[k]);
    endtask

    // lane 0 or 1: run until that queue drains; 2: until both drain.
    task automatic run_until(input int lane);
        while (((lane == 0 || lane == 2) && q0.size() > 0) ||
               ((lane == 1 || lane == 2) && q1.size() > 0)) begin
            logic [LANES-1:0] bits;
            bits[0] = (q0.size() > 0) ? q0.pop_front() : fill0;
            bits[1] = (q1.size() > 0) ? q1.pop_front() : fill1;
            step(1'b1, bits);
        end
    endtask

    function automatic logic [7:0] rand_data();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == COM) b = 8'h3C;
        return b;
    endfunction

    logic [7:0] seq31 [7];
    logic [1:0] act31 [7];

    initial begin
        reset_L = 1'b0;
        data_in = '0;
        fill0   = 1'b0;
        fill1   = 1'b0;
        model_reset();
        for (int l = 0; l < LANES; l++) pulses[l] = 0;

        // Reset held with random traffic.
        for (int n = 0; n < 6; n++) step(1'b0, LANES'($urandom_range(0, 3)));
        chk("rst_data_out", data_out, 16'h0000);
        chk("rst_valid", 16'(valid_out), 16'h0);
        chk("rst_active", 16'(active_lane), 16'h0);
        chk("rst_all_active", 16'(all_active), 16'h0);

        // Lane 0 syncs on four COMs and delivers one byte; lane 1 idle at 0.
        for (int n = 0; n < 4; n++) push_byte(0, COM);
        run_until(0);
        chk("l0_active_after_4bc", 16'(active_lane), 16'b01);
        push_byte(0, 8'h5A);
        run_until(0);
        chk("l0_valid_5a", 16'(valid_out), 16'b01);
        chk("l0_data_5a", 16'(data_out[7:0]), 16'h5A);
        chk("l0_all_active", 16'(all_active), 16'h0);
        push_byte(0, COM);
        run_until(0);
        chk("l0_single_pulse", 16'(pulses[0]), 16'd1);
        chk("l0_data_hold", 16'(data_out[7:0]), 16'h5A);

        // Lane 1 bit-slip: three garbage bits before its COM run.
        pulses[1] = 0;
        push_bit(1, 1'b1); push_bit(1, 1'b0); push_bit(1, 1'b1);
        for (int n = 0; n < 4; n++) push_byte(1, COM);
        push_byte(1, 8'hA3);
        for (int n = 0; n < 8; n++) push_byte(0, COM);
        run_until(1);
        chk("l1_valid_a3", 16'(valid_out[1]), 16'h1);
        chk("l1_data_a3", 16'(data_out[15:8]), 16'hA3);
        chk("both_active", 16'(active_lane), 16'b11);
        chk("all_active_hi", 16'(all_active), 16'h1);

        // Gap limit on lane 0: 16 data bytes pass, the 17th drops sync.
        pulses[0] = 0;
        for (int n = 0; n < 16; n++) push_byte(0, rand_data());
        for (int n = 0; n < 24; n++) push_byte(1, COM);
        run_until(0);
        chk("gap16_pulses", 16'(pulses[0]), 16'd16);
        chk("gap16_active", 16'(active_lane[0]), 16'h1);
        chk("gap16_all_active", 16'(all_active), 16'h1);
        push_byte(0, 8'h00);
        run_until(0);
        chk("gap17_pulses", 16'(pulses[0]), 16'd16);
        chk("gap17_valid", 16'(valid_out[0]), 16'h0);
        chk("gap17_active", 16'(active_lane), 16'b10);
        chk("gap17_all_active", 16'(all_active), 16'h0);

        // Re-sync lane 0, then pulse reset with both lanes active.
        for (int n = 0; n < 4; n++) push_byte(0, COM);
        for (int n = 0; n < 4; n++) push_byte(1, COM);
        run_until(0);
        chk("resync_both", 16'(active_lane), 16'b11);
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        chk("async_rst_data", data_out, 16'h0000);
        chk("async_rst_valid", 16'(valid_out), 16'h0);
        chk("async_rst_active", 16'(active_lane), 16'h0);
        chk("async_rst_all", 16'(all_active), 16'h0);
        q0.delete();
        q1.delete();
        step(1'b0, LANES'($urandom_range(0, 3)));

        // After reset: lane 0 sends plain COMs, lane 1 has a broken COM run.
        seq31 = '{COM, COM, 8'h00, COM, COM, COM, COM};
        act31 = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
        for (int k = 0; k < 7; k++) begin
            push_byte(0, COM);
            push_byte(1, seq31[k]);
            run_until(2);
            chk($sformatf("resync_byte%0d", k), 16'(active_lane), 16'(act31[k]));
        end

        // Random traffic: COM idles, data bytes and occasional bit slips.
        for (int n = 0; n < 48; n++) begin
            for (int l = 0; l < LANES; l++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r >= 90) push_bit(l, 1'($urandom_range(0, 1)));
                if (r < 40) push_byte(l, COM);
                else        push_byte(l, 8'($urandom_range(0, 255)));
            end
        end
        run_until(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
